// File: rtl/pair_feed_ctrl.sv
`default_nettype none
// ============================================================================
// pair_feed_ctrl: pairs operand words as A/B for an AND/OR unit, waits a
// settle time, captures the results and returns them over a result stream.
// Revision: 1.0
// ============================================================================
module pair_feed_ctrl #(
  parameter int WIDTH  = 5,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  input  logic [WIDTH-1:0] res_and_i,
  input  logic [WIDTH-1:0] res_or_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_and_o,
  output logic [WIDTH-1:0] m_or_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [7:0]       pair_cnt_o
);

  typedef enum logic [1:0] {
    S_GET_A  = 2'd0,
    S_GET_B  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] m_and_q, m_and_d;
  logic [WIDTH-1:0] m_or_q, m_or_d;
  logic             m_valid_q, m_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [7:0]       pair_cnt_q, pair_cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    m_and_d    = m_and_q;
    m_or_d     = m_or_q;
    m_valid_d  = m_valid_q;
    err_d      = err_q;
    pair_cnt_d = pair_cnt_q;
    case (state_q)
      S_GET_A: begin
        if (s_valid_i) begin
          op_a_d  = s_data_i;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (s_valid_i) begin
          op_b_d  = s_data_i;
          cnt_d   = 4'(SETTLE);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          m_and_d   = res_and_i;
          m_or_d    = res_or_i;
          m_valid_d = 1'b1;
          // An AND bit without the matching OR bit means the unit is broken.
          if ((res_and_i & ~res_or_i) != '0) err_d = 1'b1;
          state_d   = S_RESULT;
        end
      end
      S_RESULT: begin
        if (m_ready_i) begin
          m_valid_d  = 1'b0;
          pair_cnt_d = pair_cnt_q + 8'd1;
          state_d    = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase
    busy_d = (state_d != S_GET_A);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_GET_A;
      cnt_q      <= 4'd0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      m_and_q    <= '0;
      m_or_q     <= '0;
      m_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      pair_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      m_and_q    <= m_and_d;
      m_or_q     <= m_or_d;
      m_valid_q  <= m_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign s_ready_o  = (state_q == S_GET_A) || (state_q == S_GET_B);
  assign op_a_o     = op_a_q;
  assign op_b_o     = op_b_q;
  assign m_and_o    = m_and_q;
  assign m_or_o     = m_or_q;
  assign m_valid_o  = m_valid_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign pair_cnt_o = pair_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pair_feed_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pair_feed_ctrl: directed bench for pair_feed_ctrl (SETTLE=1 and SETTLE=0).
// Revision: 1.0
// ============================================================================
module tb_pair_feed_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Instance 1: SETTLE=1
  logic       sv = 1'b0, mr = 1'b0;
  logic [4:0] sd = '0;
  logic       sr, mv, busy, err;
  logic [4:0] opa, opb, rand1, ror1, mand, mor;
  logic [7:0] pcnt;
  logic       frc = 1'b0;
  logic [4:0] fand = '0, forr = '0;
  assign rand1 = frc ? fand : (opa & opb);
  assign ror1  = frc ? forr : (opa | opb);

  pair_feed_ctrl #(.WIDTH(5), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(sv), .s_ready_o(sr), .s_data_i(sd),
    .op_a_o(opa), .op_b_o(opb), .res_and_i(rand1), .res_or_i(ror1),
    .m_valid_o(mv), .m_ready_i(mr), .m_and_o(mand), .m_or_o(mor),
    .busy_o(busy), .err_o(err), .pair_cnt_o(pcnt)
  );

  // Instance 0: SETTLE=0
  logic       sv0 = 1'b0, mr0 = 1'b1;
  logic [4:0] sd0 = '0;
  logic       sr0, mv0, busy0, err0;
  logic [4:0] opa0, opb0, mand0, mor0;
  logic [7:0] pcnt0;

  pair_feed_ctrl #(.WIDTH(5), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(sv0), .s_ready_o(sr0), .s_data_i(sd0),
    .op_a_o(opa0), .op_b_o(opb0), .res_and_i(opa0 & opb0), .res_or_i(opa0 | opb0),
    .m_valid_o(mv0), .m_ready_i(mr0), .m_and_o(mand0), .m_or_o(mor0),
    .busy_o(busy0), .err_o(err0), .pair_cnt_o(pcnt0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] w);
    int n = 0;
    while (!sr && n < 50) begin step(); n++; end
    chk("push_ready", 32'(sr), 32'd1);
    sv = 1'b1; sd = w;
    step();
    sv = 1'b0; sd = 5'h15;
  endtask

  task automatic push0(input logic [4:0] w);
    int n = 0;
    while (!sr0 && n < 50) begin step(); n++; end
    chk("push0_ready", 32'(sr0), 32'd1);
    sv0 = 1'b1; sd0 = w;
    step();
    sv0 = 1'b0; sd0 = 5'h0A;
  endtask

  initial begin
    // Reset
    #1;
    chk("rst_opa", 32'(opa), 32'h0);
    chk("rst_mv", 32'(mv), 32'h0);
    chk("rst_pcnt", 32'(pcnt), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_sr", 32'(sr), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Basic pair, m_ready high
    mr = 1'b1;
    push(5'h0C);
    chk("basic_opa", 32'(opa), 32'h0C);
    chk("basic_busy_getb", 32'(busy), 32'd1);
    push(5'h0A);
    chk("basic_opb", 32'(opb), 32'h0A);
    chk("basic_sr_wait", 32'(sr), 32'd0);
    chk("basic_mv_e0", 32'(mv), 32'd0);
    step();
    chk("basic_mv_e1", 32'(mv), 32'd0);
    step();
    chk("basic_mv_e2", 32'(mv), 32'd1);
    chk("basic_mand", 32'(mand), 32'h08);
    chk("basic_mor", 32'(mor), 32'h0E);
    step();
    chk("basic_mv_done", 32'(mv), 32'd0);
    chk("basic_pcnt", 32'(pcnt), 32'd1);
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_mand_hold", 32'(mand), 32'h08);
    chk("basic_sr_after", 32'(sr), 32'd1);

    // Backpressure
    mr = 1'b0;
    push(5'h1F);
    push(5'h01);
    step(); step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_mv", 32'(mv), 32'd1);
      chk("bp_mand", 32'(mand), 32'h01);
      chk("bp_mor", 32'(mor), 32'h1F);
      chk("bp_sr", 32'(sr), 32'd0);
      sv = 1'b1; sd = 5'h11;
      step();
    end
    sv = 1'b0;
    chk("bp_pcnt_held", 32'(pcnt), 32'd1);
    mr = 1'b1;
    step();
    mr = 1'b0;
    chk("bp_release_mv", 32'(mv), 32'd0);
    chk("bp_release_pcnt", 32'(pcnt), 32'd2);
    step(); step();
    chk("bp_once_pcnt", 32'(pcnt), 32'd2);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_opa_notconsumed", 32'(opa), 32'h1F);

    // Gapped input
    sv = 1'b1; sd = 5'h03; step();
    sv = 1'b0; sd = 5'h1A; step();
    sd = 5'h16; step();
    chk("gap_opa", 32'(opa), 32'h03);
    chk("gap_sr_getb", 32'(sr), 32'd1);
    chk("gap_opb_old", 32'(opb), 32'h01);
    sv = 1'b1; sd = 5'h05; step();
    sv = 1'b0;
    chk("gap_opb", 32'(opb), 32'h05);
    chk("gap_sr_wait", 32'(sr), 32'd0);
    mr = 1'b1;
    step(); step();
    chk("gap_mv", 32'(mv), 32'd1);
    chk("gap_mand", 32'(mand), 32'h01);
    chk("gap_mor", 32'(mor), 32'h07);
    step();
    chk("gap_pcnt", 32'(pcnt), 32'd3);

    // Error flag
    frc = 1'b1; fand = 5'h04; forr = 5'h00;
    push(5'h06);
    push(5'h07);
    step(); step();
    chk("err_set", 32'(err), 32'd1);
    chk("err_mand", 32'(mand), 32'h04);
    chk("err_mor", 32'(mor), 32'h00);
    frc = 1'b0;
    step();
    push(5'h02);
    push(5'h03);
    step(); step();
    chk("err_good_mand", 32'(mand), 32'h02);
    step();
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_pcnt", 32'(pcnt), 32'd5);

    // Reset mid-WAIT
    push(5'h1F);
    push(5'h01);
    step();
    chk("rstw_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_opa", 32'(opa), 32'h0);
    chk("rstw_opb", 32'(opb), 32'h0);
    chk("rstw_mv", 32'(mv), 32'h0);
    chk("rstw_mand", 32'(mand), 32'h0);
    chk("rstw_err", 32'(err), 32'h0);
    chk("rstw_pcnt", 32'(pcnt), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("rstw_sr_after", 32'(sr), 32'd1);
    chk("rstw_mv_after", 32'(mv), 32'd0);
    chk("rstw_pcnt_after", 32'(pcnt), 32'd0);

    // Wrap on SETTLE=0 instance
    mr0 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [4:0] a, b;
      logic [7:0] pc;
      a  = 5'(i);
      b  = 5'(i * 7 + 3);
      pc = 8'(i + 1);
      push0(a);
      push0(b);
      chk("wrap_mv_b", 32'(mv0), 32'd0);
      step();
      chk("wrap_mv_rise", 32'(mv0), 32'd1);
      chk("wrap_mand", 32'(mand0), 32'(a & b));
      chk("wrap_mor", 32'(mor0), 32'(a | b));
      step();
      chk("wrap_pcnt", 32'(pcnt0), 32'(pc));
    end
    chk("wrap_zero", 32'(pcnt0), 32'd0);
    chk("wrap_err0", 32'(err0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pair_feed_ctrl.md
Name: pair_feed_ctrl

Overview:
- Producer/collector for the 5-bit two-operand AND/OR compute units; this block is the feeding end of their operand/result interface.
- Accepts operand words one at a time over a valid/ready stream and pairs them as A then B.
- Holds each pair stable on op_a/op_b, waits a programmable settle time, captures the unit's AND/OR results, and returns them over a valid/ready result stream.
- Keeps a sticky consistency error and a completed-pair counter.

Parameters:
- WIDTH, 5: operand/result width in bits.
- SETTLE, 1: extra wait cycles after B is accepted before results are sampled. Legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  operand word valid.
- s_ready  out  1  block accepts an operand word.
- s_data  in  WIDTH  operand word.
- op_a  out  WIDTH  operand A to the compute unit (in_0).
- op_b  out  WIDTH  operand B to the compute unit (in_1).
- res_and  in  WIDTH  compute unit AND result (out_0).
- res_or  in  WIDTH  compute unit OR result (out_1).
- m_valid  out  1  result pair valid.
- m_ready  in  1  downstream accepts the result pair.
- m_and  out  WIDTH  captured AND result.
- m_or  out  WIDTH  captured OR result.
- busy  out  1  high in every state except GET_A.
- err  out  1  sticky: a captured result had res_and & ~res_or != 0.
- pair_cnt  out  8  completed result handshakes, mod 256.

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: FSM=GET_A. op_a, op_b, m_and, m_or = 0. m_valid=0, err=0, pair_cnt=0, settle counter=0.
- Reset mid-operation aborts any partial pair or pending result with no output glitch beyond the reset values.
- Outputs: s_ready=1 only in GET_A and GET_B. All other outputs are registered.
- Handshakes: transfer occurs on a rising edge with valid&&ready. s_data is ignored when no transfer occurs.
- GET_A: on transfer, op_a<=s_data and go to GET_B.
- GET_B: on transfer, op_b<=s_data, cnt<=SETTLE, and go to WAIT. op_a is held.
- WAIT: s_ready=0 and op_a/op_b are held.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: m_and<=res_and, m_or<=res_or, m_valid<=1, go to RESULT.
  - On that same capture edge, err<=1 if (res_and & ~res_or)!=0. err clears only on reset.
- Latency: m_valid rises on the (SETTLE+1)th edge after the edge that accepted B.
- RESULT: m_valid, m_and and m_or are held stable until m_ready. On the handshake edge: m_valid<=0, pair_cnt<=pair_cnt+1 (255 wraps to 0), go to GET_A. m_and/m_or keep their last values.
- Backpressure: m_ready low holds RESULT indefinitely, and s_ready stays 0 meanwhile.
- m_ready high outside RESULT has no effect. s_valid high outside GET_A/GET_B has no effect, and the word is not consumed.
- Throughput: one pair per SETTLE+4 cycles minimum (A, B, WAIT×(SETTLE+1), RESULT handshake).
- Widths: all data paths are exactly WIDTH bits. No arithmetic on data; only cnt (4 bits) and pair_cnt (8 bits) count.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT with op_a=5'h1F -> all outputs 0 immediately, s_ready=1 after release, pair_cnt=0.
- Basic pair, SETTLE=1, bench models the AND/OR unit: send 5'h0C then 5'h0A, m_ready=1 -> m_valid two edges after B accept; m_and=5'h08, m_or=5'h0E; pair_cnt=1; err=0.
- Backpressure: send 5'h1F, 5'h01 with m_ready=0 for 10 cycles -> m_valid held 1, m_and=5'h01, m_or=5'h1F stable, s_ready=0 throughout; releasing m_ready completes exactly one handshake.
- Gapped input: s_valid toggles 1,0,0,1 with data 5'h03, X, X, 5'h05 -> op_a=5'h03, op_b=5'h05; idle cycles are not consumed.
- Error flag: force res_and=5'h04, res_or=5'h00 at capture -> err=1, and it stays 1 after subsequent good pairs until reset.
- Wrap: complete 256 pairs with SETTLE=0 -> pair_cnt returns to 0; each pair's m_valid rises one edge after B accept.
